data_binner: RTL and testbench
==============================

// Module: data_binner
// PURPOSE
//  Streaming programmable quantiser; successor to the fixed 4-bit -> 2-bit converter.
//  Maps each DATA_W-bit sample to one of NUM_BINS bins using run-time programmable thresholds.
//  Adds optional hysteresis, a valid/ready 2-stage pipeline, a bin-change flag and
//  per-bin hit counters.
//  Sits between a sensor/ADC sample stream and downstream level-based control logic.
// PARAMETERS
//  DATA_W    4                   sample width
//  NUM_BINS  4                   bin count, >=2; NUM_BINS-1 thresholds
//  BIN_W     $clog2(NUM_BINS)    bin index width (derived; do not override)
//  CNT_W     16                  per-bin hit counter width
// PORTS
//  clk          in   1                 clock, all logic on posedge
//  rst          in   1                 synchronous, active-high reset
//  cfg_we       in   1                 threshold write strobe
//  cfg_idx      in   BIN_W             threshold index, 0..NUM_BINS-2; others ignored
//  cfg_thr      in   DATA_W            threshold value
//  hyst         in   DATA_W            hysteresis margin, 0 = off; sampled at stage 1
//  in_valid     in   1                 sample valid
//  in_ready     out  1                 sample accepted when in_valid && in_ready
//  in_data      in   DATA_W            sample
//  out_valid    out  1                 result valid
//  out_ready    in   1                 result consumed when out_valid && out_ready
//  out_bin      out  BIN_W             bin index
//  out_changed  out  1                 out_bin differs from previous emitted bin
//  cnt_clr      in   1                 clear all hit counters
//  cnt_sel      in   BIN_W             counter select
//  cnt_val      out  CNT_W             combinational read of counter[cnt_sel]; 0 if sel >= NUM_BINS
// BEHAVIOUR
//  Reset:
//   - out_valid=0, out_bin=0, out_changed=0; all counters=0; history invalid.
//   - thr[k] = ((k+1)<<DATA_W)/NUM_BINS; for 4/4 this gives 4,8,12 (legacy map).
//   - In-flight samples are dropped. in_ready=1 in the first cycle after reset.
//  Raw bin r = number of k with data > thr[k]. Unsigned compare; no ordering check on thresholds.
//  Stage 1 (S1), on accept, registers:
//   - r;
//   - u = #k with data > min(thr[k]+hyst, 2^DATA_W-1);
//   - d = #k with data > max(thr[k]-hyst, 0).
//   - Invariant: u <= r <= d.
//  Stage 2 (S2), loading from S1:
//   - History invalid: new = r.
//   - Otherwise: new = (u > last) ? u : (d < last) ? d : last.
//   - out_changed = history valid && new != last.
//   - last <= new; history becomes valid.
//  Handshake:
//   - s2_adv = !out_valid || out_ready.
//   - in_ready = !s1_valid || s2_adv (combinational).
//   - Full-throughput 1 sample/cycle when out_ready=1; latency 2 cycles accept -> out_valid.
//   - Outputs hold stable while out_valid && !out_ready; no drops, no duplicates.
//  Config:
//   - A cfg_we write affects samples accepted from the next cycle on.
//   - Samples already in S1/S2 keep their old result.
//   - Writes with cfg_idx out of range are ignored.
//  Counters:
//   - counter[out_bin] +1 on each output handshake, saturating at all-ones.
//   - cnt_clr in the same cycle as a handshake: clear wins; that increment is lost.
// STRUCTURE
//  data_binner_pkg:
//   - default-threshold function;
//   - saturating add/sub helpers;
//   - count_above(data, thr_vec) function.
//  Sub-module bin_compare: combinational r/u/d from data, threshold array and hyst;
//  instantiated once in S1.
// TESTING
//  1. Reset, hyst=0, sweep in_data 0..15 with out_ready=1.
//     -> bins 0x5,1x4,2x4,3x3 (0..4->0, 5..8->1, 9..12->2, 13..15->3); 2-cycle latency.
//  2. Write thr={3,7,11}, then send 4, 8, 12.
//     -> bins 1,2,3; a sample in flight during the write uses old thresholds.
//  3. hyst=2, send 6,9,10,11,7,6,5 (last starts at 1).
//     -> bins 1,1,1,2,2,1,1; out_changed=1 only on the 11 and 6 outputs.
//  4. Stream 8 samples with out_ready toggling 1,0,0,1.
//     -> all 8 outputs in order, values held while stalled; in_ready=0 when S1 and S2 full and stalled.
//  5. CNT_W=2: 5 outputs in bin 3 -> cnt_val(sel=3)=3 (saturated).
//     cnt_clr with a simultaneous bin-3 handshake -> counter 0.
//  6. Assert rst with S1 and S2 full.
//     -> next cycle out_valid=0, counters 0, thresholds back to 4,8,12, first new output has out_changed=0.

Source files
------------

// File: rtl/data_binner_pkg.sv
// Shared helpers for the data_binner quantiser; they work on MAX_W-bit words
// so any instance with DATA_W <= MAX_W and NUM_BINS <= MAX_THR+1 can use them.
package data_binner_pkg;

    localparam int MAX_W   = 16;
    localparam int MAX_THR = 15;

    typedef logic [MAX_W-1:0]    word_t;
    typedef word_t [MAX_THR-1:0] thr_vec_t;

    // Evenly spaced thresholds; for 4-bit data and 4 bins this is the legacy 4/8/12 map.
    function automatic word_t default_thr(input int k, input int data_w, input int num_bins);
        return word_t'(((k + 1) << data_w) / num_bins);
    endfunction

    function automatic word_t sat_add(input word_t a, input word_t b, input word_t lim);
        logic [MAX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[MAX_W-1:0];
    endfunction

    function automatic word_t sat_sub(input word_t a, input word_t b);
        return (a > b) ? (a - b) : '0;
    endfunction

    function automatic int count_above(input word_t data, input thr_vec_t thr, input int n);
        int c;
        c = 0;
        for (int k = 0; k < MAX_THR; k++) begin
            if (k < n && data > thr[k]) begin
                c = c + 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/data_binner_compare.sv
// Bin search for one sample: raw bin r and the hysteresis-widened u (upper) / d (lower) bins.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is registered.
module bin_compare
    import data_binner_pkg::*;
#(
    parameter int  DATA_W   = 4,
    parameter int  NUM_BINS = 4,
    localparam int BIN_W    = $clog2(NUM_BINS)
) (
    input  logic [DATA_W-1:0]               data,
    input  logic [NUM_BINS-2:0][DATA_W-1:0] thr,
    input  logic [DATA_W-1:0]               hyst,
    output logic [BIN_W-1:0]                r,
    output logic [BIN_W-1:0]                u,
    output logic [BIN_W-1:0]                d
);

    localparam word_t TOP = word_t'((1 << DATA_W) - 1);

    thr_vec_t thr_r;
    thr_vec_t thr_u;
    thr_vec_t thr_d;
    word_t    data_ext;
    word_t    hyst_ext;

    // Unused threshold slots stay zero and are masked off by the count limit.
    always_comb begin
        thr_r    = '0;
        thr_u    = '0;
        thr_d    = '0;
        data_ext = word_t'(data);
        hyst_ext = word_t'(hyst);
        for (int k = 0; k < NUM_BINS - 1; k++) begin
            thr_r[k] = word_t'(thr[k]);
            thr_u[k] = sat_add(thr_r[k], hyst_ext, TOP);
            thr_d[k] = sat_sub(thr_r[k], hyst_ext);
        end
        r = BIN_W'(count_above(data_ext, thr_r, NUM_BINS - 1));
        u = BIN_W'(count_above(data_ext, thr_u, NUM_BINS - 1));
        d = BIN_W'(count_above(data_ext, thr_d, NUM_BINS - 1));
    end

endmodule

// File: rtl/data_binner.sv
// Streaming programmable quantiser with hysteresis, bin-change flag and per-bin hit counters.
// Latency: 2 cycles from input accept to out_valid; 1 sample/cycle while out_ready is high.
// Backpressure: valid/ready; a stalled output holds stable and in_ready drops once both stages are full.
module data_binner
    import data_binner_pkg::*;
#(
    parameter int  DATA_W   = 4,
    parameter int  NUM_BINS = 4,
    parameter int  CNT_W    = 16,
    localparam int BIN_W    = $clog2(NUM_BINS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [BIN_W-1:0]  cfg_idx,
    input  logic [DATA_W-1:0] cfg_thr,
    input  logic [DATA_W-1:0] hyst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BIN_W-1:0]  out_bin,
    output logic              out_changed,
    input  logic              cnt_clr,
    input  logic [BIN_W-1:0]  cnt_sel,
    output logic [CNT_W-1:0]  cnt_val
);

    logic [NUM_BINS-2:0][DATA_W-1:0] thr;
    logic [NUM_BINS-1:0][CNT_W-1:0]  cnt;

    logic [BIN_W-1:0] cmp_r;
    logic [BIN_W-1:0] cmp_u;
    logic [BIN_W-1:0] cmp_d;

    logic             s1_valid;
    logic [BIN_W-1:0] s1_r;
    logic [BIN_W-1:0] s1_u;
    logic [BIN_W-1:0] s1_d;

    logic             hist_valid;
    logic [BIN_W-1:0] next_bin;
    logic             s2_adv;
    logic             handshake;

    assign s2_adv    = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign handshake = out_valid && out_ready;

    bin_compare #(
        .DATA_W   (DATA_W),
        .NUM_BINS (NUM_BINS)
    ) u_cmp (
        .data (in_data),
        .thr  (thr),
        .hyst (hyst),
        .r    (cmp_r),
        .u    (cmp_u),
        .d    (cmp_d)
    );

    // Threshold table; a write lands at the edge, so the sample accepted on that edge sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_BINS - 1; k++) begin
                thr[k] <= DATA_W'(default_thr(k, DATA_W, NUM_BINS));
            end
        end else if (cfg_we && int'(cfg_idx) < NUM_BINS - 1) begin
            thr[cfg_idx] <= cfg_thr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s1_u     <= '0;
            s1_d     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_r <= cmp_r;
                s1_u <= cmp_u;
                s1_d <= cmp_d;
            end
        end
    end

    // out_bin doubles as the history register: it always holds the last emitted bin.
    always_comb begin
        next_bin = s1_r;
        if (hist_valid) begin
            if (s1_u > out_bin) begin
                next_bin = s1_u;
            end else if (s1_d < out_bin) begin
                next_bin = s1_d;
            end else begin
                next_bin = out_bin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_bin     <= '0;
            out_changed <= 1'b0;
            hist_valid  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_bin     <= next_bin;
                out_changed <= hist_valid && (next_bin != out_bin);
                hist_valid  <= 1'b1;
            end
        end
    end

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt <= '0;
        end else if (handshake && cnt[out_bin] != {CNT_W{1'b1}}) begin
            cnt[out_bin] <= cnt[out_bin] + CNT_W'(1);
        end
    end

    assign cnt_val = (int'(cnt_sel) < NUM_BINS) ? cnt[cnt_sel] : '0;

endmodule

// File: tb/tb_data_binner.sv
// Directed bench for data_binner: hand-computed bins, flags and counter values.
module tb_data_binner;

    localparam int DATA_W   = 4;
    localparam int NUM_BINS = 4;
    localparam int CNT_W    = 2;
    localparam int BIN_W    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [BIN_W-1:0]  cfg_idx;
    logic [DATA_W-1:0] cfg_thr;
    logic [DATA_W-1:0] hyst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [BIN_W-1:0]  out_bin;
    logic              out_changed;
    logic              cnt_clr;
    logic [BIN_W-1:0]  cnt_sel;
    logic [CNT_W-1:0]  cnt_val;

    int total = 0;
    int bad   = 0;

    logic [BIN_W-1:0] got_bin[$];
    logic             got_chg[$];
    int               exp_bin[$];
    int               exp_chg[$];

    logic [3:0]       v4[8];
    int               idx;
    int               low;
    logic             held;
    logic             acc;
    logic [BIN_W-1:0] hbin;
    logic             hchg;

    always #5 clk = ~clk;

    data_binner #(
        .DATA_W   (DATA_W),
        .NUM_BINS (NUM_BINS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_thr     (cfg_thr),
        .hyst        (hyst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bin     (out_bin),
        .out_changed (out_changed),
        .cnt_clr     (cnt_clr),
        .cnt_sel     (cnt_sel),
        .cnt_val     (cnt_val)
    );

    // Output monitor samples on the falling edge, half a cycle from the handshake edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_bin.push_back(out_bin);
            got_chg.push_back(out_changed);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 100 && !in_ready; n++) tick();
        if (!in_ready) chk("send_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int c = 0; c < 100 && got_bin.size() < n; c++) tick();
    endtask

    task automatic rd_cnt(input string tag, input int sel, input int exp);
        cnt_sel = 2'(sel);
        #1;
        chk(tag, 32'(cnt_val), 32'(exp));
    endtask

    task automatic cfg_write(input int i, input logic [3:0] t);
        cfg_we  = 1'b1;
        cfg_idx = 2'(i);
        cfg_thr = t;
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic cmp_out(input string tag);
        chk({tag, "_count"}, 32'(got_bin.size()), 32'(exp_bin.size()));
        for (int i = 0; i < exp_bin.size(); i++) begin
            if (i < got_bin.size()) begin
                chk($sformatf("%s_bin%0d", tag, i), 32'(got_bin[i]), 32'(exp_bin[i]));
                chk($sformatf("%s_chg%0d", tag, i), 32'(got_chg[i]), 32'(exp_chg[i]));
            end
        end
        got_bin.delete();
        got_chg.delete();
        exp_bin.delete();
        exp_chg.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_thr = '0; hyst = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1; cnt_clr = 1'b0; cnt_sel = '0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_bin", 32'(out_bin), 0);
        chk("rst_out_changed", 32'(out_changed), 0);
        rd_cnt("rst_cnt0", 0, 0);
        rd_cnt("rst_cnt3", 3, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        // Sweep with default thresholds 4/8/12 and two-cycle latency.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i);
            tick();
            if (i == 0) chk("lat_edge1_valid", 32'(out_valid), 0);
            if (i == 1) begin
                chk("lat_edge2_valid", 32'(out_valid), 1);
                chk("lat_edge2_bin", 32'(out_bin), 0);
            end
        end
        in_valid = 1'b0;
        drain(16);
        exp_bin = '{0,0,0,0,0,1,1,1,1,2,2,2,2,3,3,3};
        exp_chg = '{0,0,0,0,0,1,0,0,0,1,0,0,0,1,0,0};
        cmp_out("sweep");

        // Threshold rewrite to 3/7/11 overlapping accepted samples; idx 3 is out of range.
        cfg_we = 1'b1;
        cfg_idx = 2'd0; cfg_thr = 4'd3;  send(4'd4);
        cfg_idx = 2'd1; cfg_thr = 4'd7;  send(4'd4);
        cfg_idx = 2'd2; cfg_thr = 4'd11; send(4'd8);
        cfg_idx = 2'd3; cfg_thr = 4'd0;  send(4'd12);
        cfg_we = 1'b0;
        send(4'd4);
        send(4'd8);
        send(4'd12);
        drain(7);
        exp_bin = '{0,1,2,3,1,2,3};
        exp_chg = '{1,1,1,1,1,1,1};
        cmp_out("cfg");

        cfg_write(0, 4'd4);
        cfg_write(1, 4'd8);
        cfg_write(2, 4'd12);

        // Hysteresis 2 after seeding last=1 with hyst off.
        hyst = 4'd0;
        send(4'd6);
        hyst = 4'd2;
        send(4'd6); send(4'd9); send(4'd10); send(4'd11);
        send(4'd7); send(4'd6); send(4'd5);
        drain(8);
        hyst = 4'd0;
        exp_bin = '{1,1,1,1,2,2,1,1};
        exp_chg = '{1,0,0,0,1,0,1,0};
        cmp_out("hyst");

        // Backpressure with out_ready pattern 1,0,0,1.
        v4 = '{4'd0, 4'd15, 4'd5, 4'd10, 4'd2, 4'd13, 4'd8, 4'd9};
        idx = 0; low = 0; held = 1'b0; hbin = '0; hchg = 1'b0;
        for (int cyc = 0; cyc < 80 && got_bin.size() < 8; cyc++) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (idx < 8);
            in_data   = v4[idx[2:0]];
            #1;
            if (held) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_bin", 32'(out_bin), 32'(hbin));
                chk("hold_chg", 32'(out_changed), 32'(hchg));
            end
            held = out_valid && !out_ready;
            hbin = out_bin;
            hchg = out_changed;
            if (in_valid && !in_ready) low++;
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(8);
        chk("stall_in_ready_low_seen", 32'(low > 0), 1);
        exp_bin = '{0,3,1,2,0,3,1,2};
        exp_chg = '{1,1,1,1,1,1,1,1};
        cmp_out("stall");

        // Counters: saturation at CNT_W=2 and clear beating a same-cycle increment.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        rd_cnt("clr_cnt3", 3, 0);
        for (int i = 0; i < 5; i++) send(4'd15);
        send(4'd5);
        send(4'd5);
        drain(7);
        rd_cnt("sat_cnt3", 3, 3);
        rd_cnt("cnt1_two", 1, 2);
        rd_cnt("cnt0_zero", 0, 0);
        in_valid = 1'b1;
        in_data  = 4'd15;
        tick();
        in_valid = 1'b0;
        tick();
        chk("clr_hs_valid", 32'(out_valid), 1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        rd_cnt("clr_wins_cnt3", 3, 0);
        rd_cnt("clr_wins_cnt1", 1, 0);
        got_bin.delete();
        got_chg.delete();

        // Reset with both stages full and non-default thresholds.
        cfg_write(0, 4'd3);
        cfg_write(1, 4'd7);
        cfg_write(2, 4'd11);
        send(4'd13);
        drain(1);
        rd_cnt("pre_rst_cnt3", 3, 1);
        got_bin.delete();
        got_chg.delete();
        out_ready = 1'b0;
        send(4'd15);
        send(4'd14);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_out_valid", 32'(out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 0);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        rd_cnt("post_rst_cnt3", 3, 0);
        send(4'd13);
        send(4'd4);
        send(4'd8);
        send(4'd12);
        drain(4);
        exp_bin = '{3,0,1,2};
        exp_chg = '{0,1,1,1};
        cmp_out("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
